// File: rtl/tlul_pkg.sv
// TL-UL channel types and opcodes shared by hosts and devices on the toy chip.
// Pure type/constant package with no logic, latency or backpressure of its own.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_DUW = 4;

    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/toy_tlul_regs_pkg.sv
// Response entry type, FIFO state encoding and constants for the toy TL-UL register bank.
// Pure type/constant package with no logic, latency or backpressure of its own.
package toy_tlul_regs_pkg;

    localparam int          RspDepth = 2;
    localparam int          RspCntW  = 2;
    localparam logic [31:0] ErrRdata = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    typedef enum logic [1:0] {
        FifoEmpty = 2'd0,
        FifoOne   = 2'd1,
        FifoFull  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/toy_rsp_fifo.sv
// Two-entry response FIFO; a push is visible at the head the cycle after it is written.
// Pushes are dropped when full and pops when empty; the caller gates push with !full_o.
module toy_rsp_fifo
    import toy_tlul_regs_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  rsp_t               wdata_i,
    input  logic               pop_i,
    output rsp_t               rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [RspCntW-1:0] count_o
);

    fifo_state_e state_q, state_d;
    rsp_t        mem_q [RspDepth];
    logic        wr_ptr_q, rd_ptr_q;
    logic        push_ok, pop_ok;

    assign push_ok = push_i && (state_q != FifoFull);
    assign pop_ok  = pop_i  && (state_q != FifoEmpty);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FifoEmpty: if (push_ok) state_d = FifoOne;
            FifoOne: begin
                if (push_ok && !pop_ok)      state_d = FifoFull;
                else if (pop_ok && !push_ok) state_d = FifoEmpty;
            end
            FifoFull:  if (pop_ok) state_d = FifoOne;
            default:   state_d = FifoEmpty;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= FifoEmpty;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (state_q == FifoFull);
    assign empty_o = (state_q == FifoEmpty);
    assign count_o = state_q;

endmodule

// File: rtl/toy_tlul_regs.sv
// TL-UL register bank: requests execute on accept, responses appear one cycle later via a 2-deep FIFO;
// a_ready drops only when the FIFO is full. TOY_TLUL_REGS_PARTIAL_EN enables PutPartialData.
module toy_tlul_regs
    import tlul_pkg::*;
    import toy_tlul_regs_pkg::*;
#(
    parameter  int NumRegs = 16,
    localparam int RegAw   = $clog2(NumRegs)
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  tl_h2d_t     tl_i,
    output tl_d2h_t     tl_o,
    output logic [31:0] reg0_o,
    output logic        busy_o
);

    logic [31:0]        regs_q [NumRegs];
    logic [31:0]        regs_d [NumRegs];
    logic [RegAw-1:0]   idx;
    logic               accept, is_get, is_putf, is_putp;
    logic               err_addr, err_align, err_op, err_mask, err;
    logic               we;
    logic [3:0]         wmask;
    rsp_t               rsp_push, rsp_head;
    logic               fifo_full, fifo_empty;
    logic [RspCntW-1:0] fifo_count;

    assign accept  = tl_i.a_valid && !fifo_full;
    assign idx     = tl_i.a_address[RegAw+1:2];
    assign is_get  = (tl_i.a_opcode == Get);
    assign is_putf = (tl_i.a_opcode == PutFullData);
`ifdef TOY_TLUL_REGS_PARTIAL_EN
    assign is_putp = (tl_i.a_opcode == PutPartialData);
`else
    assign is_putp = 1'b0;
`endif

    assign err_addr  = (tl_i.a_address[31:RegAw+2] != '0);
    assign err_align = (tl_i.a_address[1:0] != 2'b00) || (tl_i.a_size != 2'd2);
    assign err_op    = !(is_get || is_putf || is_putp);
    assign err_mask  = is_putf && (tl_i.a_mask != 4'hf);
    assign err       = err_addr || err_align || err_op || err_mask;

    assign we    = accept && !err && (is_putf || is_putp);
    assign wmask = is_putf ? 4'hf : tl_i.a_mask;

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) regs_d[idx][8*b +: 8] = tl_i.a_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads sample the pre-edge register value, so a Put landing this edge is seen by the next Get.
    always_comb begin
        rsp_push        = '0;
        rsp_push.opcode = is_get ? AccessAckData : AccessAck;
        rsp_push.size   = tl_i.a_size;
        rsp_push.source = tl_i.a_source;
        rsp_push.error  = err;
        if (is_get) rsp_push.data = err ? ErrRdata : regs_q[idx];
    end

    toy_rsp_fifo u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .wdata_i (rsp_push),
        .pop_i   (tl_i.d_ready),
        .rdata_o (rsp_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        tl_o          = '0;
        tl_o.d_valid  = !fifo_empty;
        tl_o.d_opcode = rsp_head.opcode;
        tl_o.d_size   = rsp_head.size;
        tl_o.d_source = rsp_head.source;
        tl_o.d_data   = rsp_head.data;
        tl_o.d_error  = rsp_head.error;
        tl_o.a_ready  = !fifo_full;
    end

    assign reg0_o = regs_q[0];
    assign busy_o = (fifo_count != '0);

endmodule

// File: tb/tb_toy_tlul_regs.sv
// Directed bench for toy_tlul_regs: table of single transactions plus backpressure, reset and streaming sequences.
module tb_toy_tlul_regs;
    import tlul_pkg::*;

    logic        clk;
    logic        rst;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;
    logic [31:0] reg0;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    toy_tlul_regs dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_i   (tl_h),
        .tl_o   (tl_d),
        .reg0_o (reg0),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        exp_err;
        logic [2:0]  exp_op;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [20];
    int   nv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] mask, input logic [31:0] data, input logic exp_err,
                       input logic [2:0] exp_op, input logic [31:0] exp_data);
        vecs[nv] = '{op, addr, size, mask, data, exp_err, exp_op, exp_data};
        nv++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src);
        tl_h.a_valid   = 1'b1;
        tl_h.a_opcode  = op;
        tl_h.a_address = addr;
        tl_h.a_size    = 2'd2;
        tl_h.a_mask    = mask;
        tl_h.a_data    = data;
        tl_h.a_source  = src;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        tl_h.a_valid   = 1'b1;
        tl_h.a_opcode  = v.op;
        tl_h.a_address = v.addr;
        tl_h.a_size    = v.size;
        tl_h.a_mask    = v.mask;
        tl_h.a_data    = v.data;
        tl_h.a_source  = 8'(id + 8'h10);
        tl_h.d_ready   = 1'b1;
        check($sformatf("vec%0d_a_ready", id), 32'(tl_d.a_ready), 32'd1);
        tick();
        tl_h.a_valid = 1'b0;
        check($sformatf("vec%0d_d_valid", id), 32'(tl_d.d_valid), 32'd1);
        check($sformatf("vec%0d_opcode", id), 32'(tl_d.d_opcode), 32'(v.exp_op));
        check($sformatf("vec%0d_error", id), 32'(tl_d.d_error), 32'(v.exp_err));
        check($sformatf("vec%0d_data", id), tl_d.d_data, v.exp_data);
        check($sformatf("vec%0d_source", id), 32'(tl_d.d_source), 32'(id + 8'h10));
        check($sformatf("vec%0d_size", id), 32'(tl_d.d_size), 32'(v.size));
        tick();
        check($sformatf("vec%0d_drained", id), 32'(tl_d.d_valid), 32'd0);
    endtask

    logic [31:0] exp_reg0;
    logic [31:0] last_put;

    initial begin
        tl_h = '0;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_d_valid", 32'(tl_d.d_valid), 32'd0);
        check("rst_a_ready", 32'(tl_d.a_ready), 32'd1);
        check("rst_reg0", reg0, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        add(PutFullData, 32'h04, 2'd2, 4'hf, 32'hDEAD_BEEF, 1'b0, AccessAck,     32'h0);
        add(Get,         32'h04, 2'd2, 4'hf, 32'h0,        1'b0, AccessAckData, 32'hDEAD_BEEF);
        add(Get,         32'h40, 2'd2, 4'hf, 32'h0,        1'b1, AccessAckData, 32'hFFFF_FFFF);
        add(Get,         32'h06, 2'd2, 4'hf, 32'h0,        1'b1, AccessAckData, 32'hFFFF_FFFF);
        add(Get,         32'h04, 2'd2, 4'hf, 32'h0,        1'b0, AccessAckData, 32'hDEAD_BEEF);
        add(PutFullData, 32'h08, 2'd2, 4'h3, 32'h5555_5555, 1'b1, AccessAck,    32'h0);
        add(Get,         32'h08, 2'd2, 4'hf, 32'h0,        1'b0, AccessAckData, 32'h0);
        add(Get,         32'h04, 2'd1, 4'hf, 32'h0,        1'b1, AccessAckData, 32'hFFFF_FFFF);
        add(3'h2,        32'h00, 2'd2, 4'hf, 32'h1234_5678, 1'b1, AccessAck,    32'h0);
        add(PutFullData, 32'h04, 2'd2, 4'hf, 32'h1122_3344, 1'b0, AccessAck,     32'h0);
`ifdef TOY_TLUL_REGS_PARTIAL_EN
        add(PutPartialData, 32'h04, 2'd2, 4'b0101, 32'hAABB_CCDD, 1'b0, AccessAck, 32'h0);
        add(Get,         32'h04, 2'd2, 4'hf, 32'h0,        1'b0, AccessAckData, 32'h11BB_33DD);
`else
        add(PutPartialData, 32'h04, 2'd2, 4'b0101, 32'hAABB_CCDD, 1'b1, AccessAck, 32'h0);
        add(Get,         32'h04, 2'd2, 4'hf, 32'h0,        1'b0, AccessAckData, 32'h1122_3344);
`endif
        add(PutFullData, 32'h3C, 2'd2, 4'hf, 32'h0F0F_0F0F, 1'b0, AccessAck,     32'h0);
        add(Get,         32'h3C, 2'd2, 4'hf, 32'h0,        1'b0, AccessAckData, 32'h0F0F_0F0F);
        add(PutFullData, 32'h100, 2'd2, 4'hf, 32'hBAD0_BAD0, 1'b1, AccessAck,   32'h0);
        add(Get,         32'h00, 2'd2, 4'hf, 32'h0,        1'b0, AccessAckData, 32'h0);

        for (int i = 0; i < nv; i++) run_vec(vecs[i], i);
        check("tbl_reg0", reg0, 32'h0);

        // Backpressure: two Gets fill the FIFO, the third waits until the cycle after the first pop.
        tl_h.d_ready = 1'b0;
        drive(Get, 32'h04, 4'hf, 32'h0, 8'hA1);
        check("bp_rdy_a", 32'(tl_d.a_ready), 32'd1);
        tick();
        drive(Get, 32'h3C, 4'hf, 32'h0, 8'hA2);
        check("bp_rdy_b", 32'(tl_d.a_ready), 32'd1);
        tick();
        drive(Get, 32'h00, 4'hf, 32'h0, 8'hA3);
        check("bp_rdy_c_full", 32'(tl_d.a_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        tick();
        check("bp_hold_rdy", 32'(tl_d.a_ready), 32'd0);
        check("bp_hold_src", 32'(tl_d.d_source), 32'hA1);
        tl_h.d_ready = 1'b1;
        check("bp_no_comb_rdy", 32'(tl_d.a_ready), 32'd0);
        check("bp_head_a", tl_d.d_data, vecs[11].exp_data);
        tick();
        check("bp_head_b_src", 32'(tl_d.d_source), 32'hA2);
        check("bp_head_b", tl_d.d_data, 32'h0F0F_0F0F);
        check("bp_rdy_after_pop", 32'(tl_d.a_ready), 32'd1);
        tick();
        tl_h.a_valid = 1'b0;
        check("bp_head_c_src", 32'(tl_d.d_source), 32'hA3);
        check("bp_head_c_vld", 32'(tl_d.d_valid), 32'd1);
        tick();
        check("bp_empty", 32'(tl_d.d_valid), 32'd0);

        // Reset with two responses buffered.
        drive(PutFullData, 32'h00, 4'hf, 32'h1234_5678, 8'h01);
        tick();
        tl_h.a_valid = 1'b0;
        tick();
        check("rr_reg0_set", reg0, 32'h1234_5678);
        tl_h.d_ready = 1'b0;
        drive(Get, 32'h00, 4'hf, 32'h0, 8'hB1);
        tick();
        drive(Get, 32'h00, 4'hf, 32'h0, 8'hB2);
        tick();
        tl_h.a_valid = 1'b0;
        check("rr_full", 32'(tl_d.a_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_d_valid", 32'(tl_d.d_valid), 32'd0);
        check("rr_a_ready", 32'(tl_d.a_ready), 32'd1);
        check("rr_reg0", reg0, 32'd0);
        check("rr_busy", 32'(busy), 32'd0);
        tl_h.d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rr_no_stale%0d", k), 32'(tl_d.d_valid), 32'd0);
        end

        // Streaming alternate Put/Get to index 0 at one request per cycle.
        exp_reg0 = 32'h0;
        last_put = 32'h0;
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0) drive(PutFullData, 32'h00, 4'hf, 32'hA500_0000 + 32'(k), 8'(k));
            else            drive(Get,         32'h00, 4'hf, 32'h0,                 8'(k));
            check($sformatf("st%0d_a_ready", k), 32'(tl_d.a_ready), 32'd1);
            if (k > 0) begin
                check($sformatf("st%0d_d_valid", k), 32'(tl_d.d_valid), 32'd1);
                check($sformatf("st%0d_src", k), 32'(tl_d.d_source), 32'(k - 1));
                if ((k - 1) % 2 == 0) begin
                    last_put = 32'hA500_0000 + 32'(k - 1);
                    exp_reg0 = last_put;
                    check($sformatf("st%0d_ack", k), 32'(tl_d.d_opcode), 32'(AccessAck));
                end else begin
                    check($sformatf("st%0d_rdata", k), tl_d.d_data, last_put);
                end
                check($sformatf("st%0d_reg0", k), reg0, exp_reg0);
            end
            tick();
        end
        tl_h.a_valid = 1'b0;
        check("st_last_rdata", tl_d.d_data, 32'hA500_0012);
        check("st_last_src", 32'(tl_d.d_source), 32'd19);
        tick();
        check("st_drained", 32'(tl_d.d_valid), 32'd0);
        check("st_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toy_tlul_regs.md
Name: toy_tlul_regs

Overview:
- TL-UL device (responder) holding a bank of 32-bit read/write registers.
- It is the device-side counterpart to the pad-driven TL-UL host on the toy chip: it accepts Get/PutFullData/PutPartialData requests and returns AccessAck/AccessAckData.
- Requests are decoded and executed in the acceptance cycle. Responses are buffered in a 2-entry response FIFO so the host may stall d_ready.

Parameters:
- NumRegs, 16, number of 32-bit registers (power of 2, 2..256).
- RegAw, $clog2(NumRegs), derived register index width; not overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- tl_i  in  tlul_pkg::tl_h2d_t  TL-UL A channel plus d_ready
- tl_o  out  tlul_pkg::tl_d2h_t  TL-UL D channel plus a_ready
- reg0_o  out  32  live value of register 0 (scratch/observe)
- busy_o  out  1  response FIFO non-empty

Behaviour:
- Reset (clk_i edge with rst_i=1):
  - all registers 0; FIFO empty.
  - tl_o.d_valid=0, tl_o.a_ready=1, reg0_o=0, busy_o=0.
  - Reset mid-transaction discards buffered responses; no ack is issued for them.
- a_ready = (fifo count < 2). It is registered-state only; there is no combinational path from d_ready.
- Accept = a_valid && a_ready. On accept, decode in the same cycle:
  - idx = a_address[RegAw+1:2].
  - err_addr = (a_address[31:RegAw+2] != 0).
  - err_align = (a_address[1:0] != 0) || (a_size != 2).
  - err_op = opcode not in {Get, PutFullData, PutPartialData}.
  - err_mask = PutFullData with a_mask != 4'hf.
  - err = OR of the above.
- Write, on accept with Put* and !err:
  - PutFullData writes all 32 bits.
  - PutPartialData writes only the byte lanes whose a_mask bit is set.
  - Errored writes leave the registers unchanged.
- Read, on accept with Get:
  - data = reg[idx], sampled in the acceptance cycle. A Get accepted the cycle after a Put to the same index returns the new value.
  - An errored Get returns data 32'hFFFF_FFFF.
- Response entry pushed on accept:
  - d_opcode = AccessAckData for Get, AccessAck otherwise; for err_op, AccessAck.
  - d_size and d_source echo the request.
  - d_param=0, d_sink=0, d_error=err.
  - d_data = read data for Get, 0 for Put.
  - d_user = 0.
- Latency: response is visible on tl_o.d_valid one cycle after accept at the earliest.
- D channel: d_valid = FIFO non-empty, showing the head entry. Pop when d_valid && d_ready. The head is held stable while d_ready=0.
- FIFO state machine (count) EMPTY/ONE/FULL:
  - push only: count+1
  - pop only: count-1
  - push and pop: count unchanged
  - A push while FULL cannot occur because a_ready=0.
- In FULL with d_ready=1: the pop frees a slot, but a_ready rises only in the next cycle (one-cycle bubble, by design).
- Back-to-back: with d_ready held 1, the block sustains one request per cycle.
- reg0_o = reg[0], updated the cycle after a write.
- busy_o = (count != 0).

Optional Feature:
- Macro TOY_TLUL_REGS_PARTIAL_EN.
- Defined: PutPartialData is supported with byte-lane masking as above.
- Undefined: PutPartialData is treated as err_op:
  - d_error=1, AccessAck returned, no register change.
  - PutFullData and Get are unaffected.

Decomposition:
- Package toy_tlul_regs_pkg holds:
  - rsp_t struct: opcode, size, source, data, error.
  - ErrRdata = 32'hFFFF_FFFF.
  - RspDepth = 2.
- One sub-module, toy_rsp_fifo: a 2-entry FIFO of rsp_t with push/pop/full/empty/count. The register array and decode stay in the top.

Test Plan:
- PutFullData addr 0x04, data 0xDEAD_BEEF, then Get addr 0x04 with d_ready=1 -> AccessAck with d_error=0, then AccessAckData with d_data=0xDEAD_BEEF; each response 1 cycle after its accept.
- Get addr 0x40 (idx out of range for NumRegs=16) -> d_error=1, d_data=0xFFFF_FFFF. Get addr 0x06 -> d_error=1. Neither alters any register.
- d_ready=0 while issuing 3 Gets -> first two accepted, a_ready=0 on the third. Raise d_ready -> responses drain in order, with the third accepted the cycle after the first pop.
- With TOY_TLUL_REGS_PARTIAL_EN defined: reg1=0x1122_3344, then PutPartialData addr 0x04 mask 4'b0101 data 0xAABB_CCDD -> reg1=0x11BB_33DD. Without the macro: d_error=1 and reg1 unchanged.
- Assert rst_i while 2 responses are buffered -> next cycle d_valid=0, a_ready=1, reg0_o=0; no stale response appears after reset.
- Continuous alternating Put/Get to idx 0 with d_ready=1 for 20 cycles -> one accept per cycle, reg0_o tracks the written data, every Get returns the preceding Put's value.
